// File: rtl/qspi_rx_frontend_pkg.sv
// Shared constants, reader/writer state encodings and the FIFO entry type
// for the QSPI receive frontend.
package qspi_rx_frontend_pkg;

  localparam int ENCRYPTER_QSPI_COUNT  = 32;
  localparam int BURST_NIBBLES_DEFAULT = ENCRYPTER_QSPI_COUNT;
  localparam int FIFO_DEPTH_DEFAULT    = 128;

  localparam logic [3:0] CMD_KEY  = 4'h1;
  localparam logic [3:0] CMD_DATA = 4'h0;

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_PROG   = 2'd1;
  localparam logic [1:0] RD_WAIT   = 2'd2;
  localparam logic [1:0] RD_STREAM = 2'd3;

  localparam logic [2:0] WR_OFF  = 3'd0;
  localparam logic [2:0] WR_IDLE = 3'd1;
  localparam logic [2:0] WR_CMD  = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_SKIP = 3'd4;

  typedef struct packed {
    logic       is_cmd;
    logic [3:0] nibble;
  } fifo_entry_t;

  function automatic logic is_valid_cmd(input logic [3:0] nib);
    return (nib == CMD_KEY) || (nib == CMD_DATA);
  endfunction

endpackage

// File: rtl/qspi_rx_fifo.sv
// FIFO with a speculative write pointer and a committed write pointer;
// the reader only ever sees entries up to the committed pointer.
module qspi_rx_fifo
  import qspi_rx_frontend_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  fifo_entry_t wr_data_i,
  input  logic        commit_i,
  input  logic        rollback_i,
  input  logic        rd_en_i,
  output fifo_entry_t rd_head_o,
  output fifo_entry_t rd_next_o,
  output logic        full_o,
  output logic [AW:0] cmt_count_o,
  output logic [AW:0] free_count_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  fifo_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] rd_ptr_inc_s;
  logic        do_write_s;

  assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_write_s   = wr_en_i && !full_o && !rollback_i;
  assign rd_ptr_inc_s = rd_ptr_q + PTR_ONE;
  assign cmt_count_o  = cmt_ptr_q - rd_ptr_q;
  assign free_count_o = DEPTH_P - (wr_ptr_q - rd_ptr_q);
  assign rd_head_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_next_o    = mem_q[rd_ptr_inc_s[AW-1:0]];

  // Rollback beats a same-cycle write: the speculative frame is abandoned.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (rollback_i) begin
      wr_ptr_d = cmt_ptr_q;
    end else if (do_write_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (commit_i) cmt_ptr_d = wr_ptr_q + PTR_ONE;
      else          cmt_ptr_d = cmt_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_i && (cmt_ptr_q != rd_ptr_q)) rd_ptr_d = rd_ptr_inc_s;
    else                                    rd_ptr_d = rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/qspi_rx_frontend.sv
// Oversampling QSPI receiver that frames host traffic into burst-sized FIFO
// commits and streams them to the Parallelizer. Optional: QSPI_RX_STATS_EN.
module qspi_rx_frontend
  import qspi_rx_frontend_pkg::*;
#(
  parameter int BURST_NIBBLES = BURST_NIBBLES_DEFAULT,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_in,
  input  logic        cs_n_in,
  input  logic [3:0]  io_in,
  output logic        qspi_busy,
  output logic [3:0]  qspi_data,
  output logic        qspi_sending,
  input  logic        qspi_ready,
  output logic        prog,
  input  logic        err_clear,
  output logic        overflow,
  output logic        frame_err,
  output logic        cmd_err
`ifdef QSPI_RX_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
`endif
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = $clog2(BURST_NIBBLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST_NIBBLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0] BURST_P     = (AW + 1)'(BURST_NIBBLES);
  localparam logic [AW:0] BUSY_LIMIT  = (AW + 1)'(BURST_NIBBLES + 1);

  logic [1:0]    sclk_sync_q, cs_sync_q;
  logic [3:0]    io_s1_q, io_s2_q;
  logic          sclk_prev_q, cs_prev_q, sample_s, cs_rise_s;
  logic [2:0]    wr_state_q, wr_state_d;
  logic [CW-1:0] cnt_q, cnt_d, xfer_q, xfer_d;
  logic          pend_q, pend_d;
  logic          wr_en_s, commit_s, rollback_s, rd_en_s, fifo_full_s;
  fifo_entry_t   wr_entry_s, head_s, next_s;
  logic [AW:0]   cmt_count_s, free_count_s;
  logic          ovf_evt_s, ferr_evt_s, cerr_evt_s, ok_evt_s, drop_evt_s;
  logic [1:0]    rd_state_q, rd_state_d;
  logic [3:0]    data_q, data_d;
  logic          sending_q, prog_q, busy_q, ovf_q, ferr_q, cerr_q;

  // Samples are qualified with the pre-edge cs_n so a sample coincident with cs_n rise still counts.
  assign sample_s  = sclk_sync_q[1] & ~sclk_prev_q & ~cs_prev_q;
  assign cs_rise_s = cs_sync_q[1] & ~cs_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b00;
      io_s1_q     <= 4'h0;
      io_s2_q     <= 4'h0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_in};
      cs_sync_q   <= {cs_sync_q[0], cs_n_in};
      io_s1_q     <= io_in;
      io_s2_q     <= io_s1_q;
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  qspi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wr_en_s),
    .wr_data_i    (wr_entry_s),
    .commit_i     (commit_s),
    .rollback_i   (rollback_s),
    .rd_en_i      (rd_en_s),
    .rd_head_o    (head_s),
    .rd_next_o    (next_s),
    .full_o       (fifo_full_s),
    .cmt_count_o  (cmt_count_s),
    .free_count_o (free_count_s)
  );

  // Writer: WR_OFF waits for cs_n high after reset; WR_SKIP ignores the rest of a bad frame.
  always_comb begin
    wr_state_d = wr_state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    wr_en_s    = 1'b0;
    wr_entry_s = {1'b0, io_s2_q};
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    ovf_evt_s  = 1'b0;
    ferr_evt_s = 1'b0;
    cerr_evt_s = 1'b0;
    ok_evt_s   = 1'b0;
    drop_evt_s = 1'b0;
    case (wr_state_q)
      WR_OFF:  if (cs_sync_q[1]) wr_state_d = WR_IDLE; else wr_state_d = WR_OFF;
      WR_IDLE: if (!cs_sync_q[1]) wr_state_d = WR_CMD; else wr_state_d = WR_IDLE;
      WR_CMD: begin
        if (!sample_s) begin
          wr_state_d = WR_CMD;
        end else if (!is_valid_cmd(io_s2_q)) begin
          cerr_evt_s = 1'b1;
          wr_state_d = WR_SKIP;
        end else if (fifo_full_s) begin
          ovf_evt_s  = 1'b1;
          rollback_s = 1'b1;
          wr_state_d = WR_SKIP;
        end else begin
          wr_en_s    = 1'b1;
          wr_entry_s = {1'b1, io_s2_q};
          pend_d     = 1'b1;
          cnt_d      = '0;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (!sample_s) begin
          wr_state_d = WR_DATA;
        end else if (fifo_full_s) begin
          ovf_evt_s  = 1'b1;
          rollback_s = 1'b1;
          pend_d     = 1'b0;
          wr_state_d = WR_SKIP;
        end else if (cnt_q == CNT_LAST) begin
          wr_en_s  = 1'b1;
          commit_s = 1'b1;
          cnt_d    = '0;
          pend_d   = 1'b0;
        end else begin
          wr_en_s = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          pend_d  = 1'b1;
        end
      end
      WR_SKIP: wr_state_d = WR_SKIP;
      default: wr_state_d = WR_OFF;
    endcase
    if (cs_rise_s && (wr_state_q == WR_CMD || wr_state_q == WR_DATA || wr_state_q == WR_SKIP)) begin
      if (wr_state_d == WR_SKIP) begin
        drop_evt_s = 1'b1;
      end else if (pend_d) begin
        rollback_s = 1'b1;
        ferr_evt_s = 1'b1;
        drop_evt_s = 1'b1;
      end else if (wr_state_d == WR_DATA) begin
        ok_evt_s = 1'b1;
      end else begin
        ok_evt_s = 1'b0;
      end
      wr_state_d = WR_IDLE;
      pend_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      drop_evt_s = drop_evt_s;
    end
  end

  // Reader: pops the command on arrival, then streams exactly one burst per pass.
  always_comb begin
    rd_state_d = rd_state_q;
    xfer_d     = xfer_q;
    rd_en_s    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (cmt_count_s == '0) begin
          rd_state_d = RD_IDLE;
        end else if (head_s.is_cmd) begin
          rd_en_s    = 1'b1;
          rd_state_d = (head_s.nibble == CMD_KEY) ? RD_PROG : RD_WAIT;
        end else begin
          rd_state_d = RD_WAIT;
        end
      end
      RD_PROG: rd_state_d = RD_WAIT;
      RD_WAIT: begin
        if ((cmt_count_s >= BURST_P) && qspi_ready) begin
          rd_state_d = RD_STREAM;
          xfer_d     = '0;
        end else begin
          rd_state_d = RD_WAIT;
        end
      end
      RD_STREAM: begin
        if (!qspi_ready) begin
          rd_state_d = RD_STREAM;
        end else if (xfer_q == CNT_LAST) begin
          rd_en_s    = 1'b1;
          rd_state_d = RD_IDLE;
          xfer_d     = '0;
        end else begin
          rd_en_s = 1'b1;
          xfer_d  = xfer_q + CNT_ONE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (rd_state_d == RD_STREAM) data_d = rd_en_s ? next_s.nibble : head_s.nibble;
    else                         data_d = 4'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_OFF;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rd_state_q <= RD_IDLE;
      xfer_q     <= '0;
      data_q     <= 4'h0;
      sending_q  <= 1'b0;
      prog_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rd_state_q <= rd_state_d;
      xfer_q     <= xfer_d;
      data_q     <= data_d;
      sending_q  <= (rd_state_d == RD_STREAM);
      prog_q     <= (rd_state_d == RD_PROG);
      busy_q     <= (free_count_s < BUSY_LIMIT);
      ovf_q      <= (ovf_q & ~err_clear) | ovf_evt_s;
      ferr_q     <= (ferr_q & ~err_clear) | ferr_evt_s;
      cerr_q     <= (cerr_q & ~err_clear) | cerr_evt_s;
    end
  end

  assign qspi_busy    = busy_q;
  assign qspi_data    = data_q;
  assign qspi_sending = sending_q;
  assign prog         = prog_q;
  assign overflow     = ovf_q;
  assign frame_err    = ferr_q;
  assign cmd_err      = cerr_q;

`ifdef QSPI_RX_STATS_EN
  logic [15:0] frames_ok_q, frames_dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_ok_q      <= 16'h0000;
      frames_dropped_q <= 16'h0000;
    end else begin
      if (ok_evt_s && (frames_ok_q != 16'hFFFF)) frames_ok_q <= frames_ok_q + 16'd1;
      if (drop_evt_s && (frames_dropped_q != 16'hFFFF)) frames_dropped_q <= frames_dropped_q + 16'd1;
    end
  end

  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: doc/qspi_rx_frontend.md
Name: qspi_rx_frontend

Overview:
- Upstream of the Parallelizer: receives raw quad-SPI (sclk, cs_n, io[3:0]) from the external host and oversamples it on clk.
- Frames the host traffic into whole encrypter-width bursts and buffers them in a FIFO.
- Drives the Parallelizer's qspi_data/qspi_sending/prog interface gaplessly, honouring qspi_ready.
- Replaces the hand-driven stimulus currently feeding the Parallelizer.

Parameters:
- BURST_NIBBLES, 32, nibbles per burst (one encrypter block, equals ENCRYPTER_QSPI_COUNT).
- FIFO_DEPTH, 128, FIFO entries; power of two, at least 2*BURST_NIBBLES+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sclk_in  in  1  raw QSPI clock; asynchronous to clk.
- cs_n_in  in  1  raw chip select, active-low.
- io_in  in  4  raw QSPI data.
- qspi_busy  out  1  flow control to host: 1 when fewer than BURST_NIBBLES+1 entries are free.
- qspi_data  out  4  nibble to Parallelizer.
- qspi_sending  out  1  burst in progress.
- qspi_ready  in  1  Parallelizer accepts a nibble this cycle.
- prog  out  1  one-cycle key-program pulse.
- err_clear  in  1  clears the sticky flags.
- overflow  out  1  sticky: frame dropped because the FIFO was full.
- frame_err  out  1  sticky: partial burst discarded.
- cmd_err  out  1  sticky: unknown command nibble.

Behaviour:
- Reset:
  - Clock: one clock, clk; reset is synchronous and active-high.
  - All outputs 0; pointers, counters and FSM cleared.
  - armed=0: the writer ignores all traffic until cs_n is seen high.
  - A reset mid-frame therefore discards the remainder of that frame.
- Input sync:
  - 2-flop synchronizers on sclk, cs_n and io, then a registered sclk edge detect.
  - A nibble is sampled on a synchronized sclk rise while cs_n=0.
  - Nibble reaches the FIFO 3 clk after the pin edge.
  - Host requirement: sclk high and low each >= 2 clk periods.
- FIFO entry: 5 bits, {is_cmd, nibble}.
- Writer:
  - First nibble after cs_n falls is the command: 0x1 = key frame, 0x0 = data frame.
  - The command is written with is_cmd=1.
  - Any other command: cmd_err=1; the rest of the frame is ignored until cs_n rises.
  - Subsequent nibbles are written with is_cmd=0.
  - Commit: when the nibble count in the current burst reaches BURST_NIBBLES, the committed write pointer advances. The first commit also includes the command entry.
  - cs_n rise with a partial burst pending: write pointer rolls back to the last commit, frame_err=1.
  - cs_n rise with no data after the command: the command entry is discarded too, frame_err=1.
  - Write while full: roll back, overflow=1, ignore until cs_n rises.
  - Simultaneous sample and cs_n rise: the sample is taken first, then the commit/rollback check.
- Reader sees committed entries only.
- Reader FSM:
  - IDLE:
    - If the head entry is a command, pop it.
    - 0x1 goes to PROG.
    - 0x0 goes to WAIT.
    - A non-command head (continuation burst) goes to WAIT.
  - PROG: prog=1 for exactly one cycle, then WAIT.
  - WAIT: when committed count >= BURST_NIBBLES and qspi_ready=1, go to STREAM; qspi_sending=1 from the next cycle.
  - STREAM:
    - qspi_sending=1 and qspi_data = head nibble.
    - Pop and count on each cycle with qspi_ready=1.
    - qspi_ready=0 holds the data; qspi_sending stays 1.
    - After BURST_NIBBLES transfers: qspi_sending=0 next cycle, go to IDLE.
- Count arithmetic: pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally; full/empty are derived from the MSB compare.
- Flags: sticky; cleared by err_clear or reset. err_clear together with a new error event leaves the flag set.

Optional Feature:
- QSPI_RX_STATS_EN defined: adds 16-bit saturating outputs frames_ok (cs_n rise with no rollback) and frames_dropped (any rollback or cmd_err frame). Both are cleared by reset only and hold at 0xFFFF.
- Undefined: these ports and counters are absent.

Decomposition:
- Shared package/constants:
  - BURST_NIBBLES default tied to ENCRYPTER_QSPI_COUNT.
  - CMD_KEY=4'h1 and CMD_DATA=4'h0.
  - Reader state enum {IDLE, PROG, WAIT, STREAM}.
  - FIFO entry typedef.
- Sub-module qspi_rx_fifo: dual-pointer FIFO with a commit/rollback write pointer. The frontend holds sync, framing and the FSM.

Test Plan:
- Key frame: cmd 0x1 plus nibbles 0..F,0..F (32), qspi_ready=1 -> prog pulse 1 cycle, then qspi_sending for 32 cycles carrying 0x0..0xF,0x0..0xF, no flags.
- Data frame of 64 nibbles, qspi_ready toggling 1/0 each cycle -> two bursts, each 32 nibbles in order; data held while ready=0; no prog.
- Frame of cmd 0x0 plus 40 nibbles -> one 32-nibble burst emitted, the last 8 dropped, frame_err=1; err_clear -> 0.
- Command 0x7 plus 32 nibbles -> nothing emitted, cmd_err=1; a following valid data frame is delivered normally.
- Host ignores qspi_busy, sends 5 bursts with qspi_ready=0 -> overflow=1, first 3 bursts retained; releasing ready streams 96 nibbles.
- Reset asserted mid-frame with cs_n low -> outputs 0; the rest of that frame is ignored; the next frame after cs_n high is delivered.
